// File: rtl/reorder_buffer.sv
// In-order retirement buffer: tags issued instrs, collects writebacks, retires one per cycle,
// drives store-buffer commit/discard and branch redirect. Optional macro: ROB_WB_BYPASS_EN.
module reorder_buffer #(
   parameter  int unsigned ROB_SIZE          = 8,
   parameter  int unsigned STORE_BUFFER_SIZE = 4,
   parameter  int unsigned XLEN              = 32,
   localparam int unsigned IW                = $clog2(ROB_SIZE),
   localparam int unsigned SW                = $clog2(STORE_BUFFER_SIZE)
) (
   input  logic                         clk_i,
   input  logic                         rstn_i,
   input  logic                         alloc_valid_i,
   output logic                         alloc_ready_o,
   output logic [IW-1:0]                alloc_rob_idx_o,
   input  logic [4:0]                   alloc_rd_i,
   input  logic                         alloc_we_i,
   input  logic                         alloc_is_store_i,
   input  logic                         wb_valid_i,
   input  logic [IW-1:0]                wb_rob_idx_i,
   input  logic [XLEN-1:0]              wb_result_i,
   input  logic [SW-1:0]                wb_store_buffer_idx_i,
   input  logic                         wb_branch_taken_i,
   input  logic [XLEN-1:0]              wb_branched_pc_i,
   input  logic [IW-1:0]                check_alive_i,
   output logic                         still_alive_o,
   output logic                         commit_valid_o,
   output logic                         commit_we_o,
   output logic [4:0]                   commit_rd_o,
   output logic [XLEN-1:0]              commit_data_o,
   output logic                         commited_store_buffer_o,
   output logic [SW-1:0]                commited_store_buffer_idx_o,
   output logic [STORE_BUFFER_SIZE-1:0] discard_store_buffer_o,
   output logic                         flush_o,
   output logic [XLEN-1:0]              flush_pc_o
);

   typedef struct packed {
      logic            valid;
      logic            done;
      logic [4:0]      rd;
      logic            we;
      logic            is_store;
      logic [XLEN-1:0] result;
      logic [SW-1:0]   sb_idx;
      logic            br_taken;
      logic [XLEN-1:0] br_pc;
   } entry_t;

   entry_t          rob [ROB_SIZE];
   logic [IW-1:0]   head;
   logic [IW-1:0]   tail;
   logic [IW:0]     count;

   entry_t          head_e;
   logic            hit;
   logic            commit;
   logic            flush;
   logic            alloc_fire;
   logic [XLEN-1:0] c_result;
   logic [SW-1:0]   c_sb_idx;
   logic            c_br_taken;
   logic [XLEN-1:0] c_br_pc;

   // Head retirement; with bypass the head may retire straight from the writeback port
   always_comb begin
      head_e     = rob[head];
      hit        = 1'b0;
      c_result   = head_e.result;
      c_sb_idx   = head_e.sb_idx;
      c_br_taken = head_e.br_taken;
      c_br_pc    = head_e.br_pc;
`ifdef ROB_WB_BYPASS_EN
      hit = head_e.valid && !head_e.done && wb_valid_i && (wb_rob_idx_i == head);
      if (hit) begin
         c_result   = wb_result_i;
         c_sb_idx   = wb_store_buffer_idx_i;
         c_br_taken = wb_branch_taken_i;
         c_br_pc    = wb_branched_pc_i;
      end
`endif
      commit = rstn_i && head_e.valid && (head_e.done || hit);
      flush  = commit && c_br_taken;
   end

   // Younger completed stores already hold a store-buffer slot that must be released
   always_comb begin
      discard_store_buffer_o = '0;
      for (int unsigned i = 0; i < ROB_SIZE; i++) begin
         if (flush && (IW'(i) != head) && rob[i].valid && rob[i].done && rob[i].is_store)
            discard_store_buffer_o[rob[i].sb_idx] = 1'b1;
      end
   end

   assign alloc_ready_o               = (count != (IW+1)'(ROB_SIZE)) && !flush;
   assign alloc_fire                  = alloc_valid_i && alloc_ready_o;
   assign alloc_rob_idx_o             = tail;
   assign still_alive_o               = rob[check_alive_i].valid && !flush;
   assign commit_valid_o              = commit;
   assign commit_we_o                 = commit && head_e.we;
   assign commit_rd_o                 = commit ? head_e.rd : 5'd0;
   assign commit_data_o               = commit ? c_result : '0;
   assign commited_store_buffer_o     = commit && head_e.is_store;
   assign commited_store_buffer_idx_o = (commit && head_e.is_store) ? c_sb_idx : '0;
   assign flush_o                     = flush;
   assign flush_pc_o                  = flush ? c_br_pc : '0;

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int unsigned i = 0; i < ROB_SIZE; i++) rob[i] <= '0;
      end else begin
         if (wb_valid_i && rob[wb_rob_idx_i].valid) begin
            rob[wb_rob_idx_i].done     <= 1'b1;
            rob[wb_rob_idx_i].result   <= wb_result_i;
            rob[wb_rob_idx_i].sb_idx   <= wb_store_buffer_idx_i;
            rob[wb_rob_idx_i].br_taken <= wb_branch_taken_i;
            rob[wb_rob_idx_i].br_pc    <= wb_branched_pc_i;
         end
         if (alloc_fire) begin
            rob[tail].valid    <= 1'b1;
            rob[tail].done     <= 1'b0;
            rob[tail].rd       <= alloc_rd_i;
            rob[tail].we       <= alloc_we_i;
            rob[tail].is_store <= alloc_is_store_i;
            rob[tail].br_taken <= 1'b0;
            tail               <= tail + IW'(1);
         end
         if (commit) begin
            rob[head].valid <= 1'b0;
            head            <= head + IW'(1);
         end
         // Taken branch retires; everything younger is squashed and the buffer empties
         if (flush) begin
            for (int unsigned i = 0; i < ROB_SIZE; i++) rob[i].valid <= 1'b0;
            tail  <= head + IW'(1);
            count <= '0;
         end else if (alloc_fire && !commit) begin
            count <= count + (IW+1)'(1);
         end else if (commit && !alloc_fire) begin
            count <= count - (IW+1)'(1);
         end
      end
   end

endmodule
